// File: rtl/freq_gate_ctrl_if.sv
// Measurement request/result bundle for the frequency-meter sequencer.
// The master drives the test signal and run controls; the slave returns the latched result.
interface freq_gate_ctrl_if #(
  parameter int unsigned CNT_W = 28
);
  logic             sig_in;
  logic             start;
  logic             auto_run;
  logic [CNT_W-1:0] freq;
  logic             freq_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output sig_in,
    output start,
    output auto_run,
    input  freq,
    input  freq_valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  sig_in,
    input  start,
    input  auto_run,
    output freq,
    output freq_valid,
    output overflow,
    output busy
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Frequency-meter sequencer: counts synchronized sig_in rising edges over a fixed gate window,
// latches the saturated count, then idles for a hold gap (repeating while auto_run is high).
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES = 48_000_000,
  parameter int unsigned HOLD_CYCLES = 4_800_000,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned MAX_COUNT   = 99_999_999
) (
  input logic             sys_clk,
  input logic             sys_rst,
  freq_gate_ctrl_if.slave bus
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StGate, StHold} state_e;

  state_e           r_state;
  logic [GateW-1:0] r_gate_cnt;
  logic [HoldW-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_freq;
  logic             r_freq_valid;
  logic             r_overflow;
  logic             r_busy;
  logic             r_sync1, r_sync2, r_sync3;

  logic             w_edge;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= bus.sig_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_sync3;

  // Count including this cycle's edge so the last gate cycle's edge reaches the latch.
  always_comb begin
    w_cnt_nxt = r_edge_cnt;
    w_ovf_nxt = r_ovf;
    if (w_edge) begin
      if (r_edge_cnt < CNT_W'(MAX_COUNT)) begin
        w_cnt_nxt = r_edge_cnt + CNT_W'(1);
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= StIdle;
      r_gate_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_freq       <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start || bus.auto_run) begin
            r_state    <= StGate;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StGate: begin
          r_gate_cnt <= r_gate_cnt + GateW'(1);
          r_edge_cnt <= w_cnt_nxt;
          r_ovf      <= w_ovf_nxt;
          if (r_gate_cnt == GateW'(GATE_CYCLES - 1)) begin
            r_freq       <= w_cnt_nxt;
            r_overflow   <= w_ovf_nxt;
            r_freq_valid <= 1'b1;
            r_hold_cnt   <= '0;
            r_state      <= StHold;
          end
        end
        StHold: begin
          r_hold_cnt <= r_hold_cnt + HoldW'(1);
          if (r_hold_cnt == HoldW'(HOLD_CYCLES - 1)) begin
            if (bus.auto_run) begin
              r_state    <= StGate;
              r_gate_cnt <= '0;
              r_edge_cnt <= '0;
              r_ovf      <= 1'b0;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freq       = r_freq;
  assign bus.freq_valid = r_freq_valid;
  assign bus.overflow   = r_overflow;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl with a 100-cycle gate, 10-cycle hold and saturation at 20.
module tb_freq_gate_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   per = 0;
  int   ph  = 0;

  freq_gate_ctrl_if #(.CNT_W(28)) ifc ();

  freq_gate_ctrl #(
    .GATE_CYCLES(100),
    .HOLD_CYCLES(10),
    .CNT_W      (28),
    .MAX_COUNT  (20)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (ifc.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one clock; sample/drive 1 ns after the edge; sig_in is a square wave of period per.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (per == 0) begin
      ifc.sig_in = 1'b0;
    end else begin
      ph = ph % per;
      ifc.sig_in = (ph < per / 2);
      ph = (ph + 1) % per;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_shot(input int exp_f, input int exp_o);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("shot_busy_rise", 32'(ifc.busy), 1);
    repeat (99) tick();
    chk("shot_fv_early", 32'(ifc.freq_valid), 0);
    tick();
    chk("shot_fv", 32'(ifc.freq_valid), 1);
    chk("shot_freq", 32'(ifc.freq), 32'(exp_f));
    chk("shot_ovf", 32'(ifc.overflow), 32'(exp_o));
    repeat (9) tick();
    chk("shot_busy_hold", 32'(ifc.busy), 1);
    tick();
    chk("shot_busy_fall", 32'(ifc.busy), 0);
    chk("shot_freq_held", 32'(ifc.freq), 32'(exp_f));
  endtask

  initial begin
    int n_fv;
    logic [31:0] f_seen;
    sys_rst      = 1'b1;
    ifc.sig_in   = 1'b0;
    ifc.start    = 1'b0;
    ifc.auto_run = 1'b0;
    per = 3;

    // Reset with sig_in toggling.
    repeat (5) begin
      tick();
      chk("rst_freq", 32'(ifc.freq), 0);
      chk("rst_ovf", 32'(ifc.overflow), 0);
      chk("rst_fv", 32'(ifc.freq_valid), 0);
      chk("rst_busy", 32'(ifc.busy), 0);
    end
    sys_rst = 1'b0;
    repeat (3) tick();
    chk("idle_busy", 32'(ifc.busy), 0);

    // Single shot, period 10.
    per = 10;
    repeat (10) tick();
    run_shot(10, 0);

    // Overflow at period 2, then recovery at period 20.
    per = 2;
    repeat (10) tick();
    run_shot(20, 1);
    per = 20;
    repeat (10) tick();
    run_shot(5, 0);

    // Auto-run: pulses at 101, 211, 321; drop auto_run mid third gate.
    per = 10;
    repeat (10) tick();
    ifc.auto_run = 1'b1;
    tick();
    chk("auto_busy", 32'(ifc.busy), 1);
    repeat (100) tick();
    chk("auto_fv1", 32'(ifc.freq_valid), 1);
    chk("auto_freq1", 32'(ifc.freq), 10);
    repeat (109) tick();
    chk("auto_fv_gap", 32'(ifc.freq_valid), 0);
    chk("auto_busy_gap", 32'(ifc.busy), 1);
    tick();
    chk("auto_fv2", 32'(ifc.freq_valid), 1);
    chk("auto_freq2", 32'(ifc.freq), 10);
    repeat (60) tick();
    ifc.auto_run = 1'b0;
    repeat (50) tick();
    chk("auto_fv3", 32'(ifc.freq_valid), 1);
    chk("auto_freq3", 32'(ifc.freq), 10);
    chk("auto_ovf3", 32'(ifc.overflow), 0);
    repeat (9) tick();
    chk("auto_busy_hold", 32'(ifc.busy), 1);
    tick();
    chk("auto_busy_fall", 32'(ifc.busy), 0);
    repeat (20) tick();
    chk("auto_stays_idle", 32'(ifc.busy), 0);

    // Reset at gate cycle 50 aborts the measurement.
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (50) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("abort_busy", 32'(ifc.busy), 0);
    chk("abort_freq", 32'(ifc.freq), 0);
    chk("abort_fv", 32'(ifc.freq_valid), 0);
    n_fv = 0;
    repeat (150) begin
      tick();
      if (ifc.freq_valid === 1'b1) n_fv++;
    end
    chk("abort_no_fv", 32'(n_fv), 0);
    chk("abort_idle", 32'(ifc.busy), 0);
    run_shot(10, 0);

    // Second start during gate is ignored; no edges gives zero.
    per = 0;
    repeat (10) tick();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (20) tick();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    n_fv   = 0;
    f_seen = 32'hffff_ffff;
    repeat (250) begin
      tick();
      if (ifc.freq_valid === 1'b1) begin
        n_fv++;
        f_seen = 32'(ifc.freq);
      end
    end
    chk("ign_fv_count", 32'(n_fv), 1);
    chk("ign_freq", f_seen, 0);
    chk("ign_ovf", 32'(ifc.overflow), 0);
    chk("ign_busy", 32'(ifc.busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
